// File: rtl/eight_bit_int_square_finder_pkg.sv
// Shared constants for the square finder and its companion square-root finder:
// operand/result/odd-term widths and the controller state encoding.
package eight_bit_int_square_finder_pkg;

    localparam int OP_W  = 8;   // operand and term counter width
    localparam int RES_W = 16;  // accumulator and result width
    localparam int DEL_W = 10;  // odd-term register width (largest term is 511)

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage : eight_bit_int_square_finder_pkg

// File: rtl/eight_bit_int_square_finder_datapath.sv
// Datapath of the square finder: sums the odd numbers 1, 3, 5, ... until
// CNT equals the latched operand, so ACC ends up holding A*A.
module eight_bit_int_square_finder_datapath
    import eight_bit_int_square_finder_pkg::*;
(
    input  logic             clk,
    input  logic             clr,
    input  logic             en_a,     // latch the operand
    input  logic             en_calc,  // update CNT/DEL/ACC
    input  logic             en_out,   // copy ACC into SQ
    input  logic             ld_add,   // 1: initialise CNT/DEL/ACC, 0: add one odd term
    input  logic [OP_W-1:0]  a,
    output logic             eq,       // all A odd terms have been summed
    output logic [RES_W-1:0] sq
);

    logic [OP_W-1:0]  a_q;
    logic [OP_W-1:0]  cnt_q;
    logic [DEL_W-1:0] del_q;
    logic [RES_W-1:0] acc_q;
    logic [RES_W-1:0] sq_q;

    logic [RES_W-1:0] acc_sum;
    logic [DEL_W-1:0] del_nxt;
    logic [OP_W-1:0]  cnt_nxt;

    // Adders are exactly register width; 255*255 and 2*255+1 both fit, so no carry is lost.
    assign acc_sum = acc_q + {{(RES_W-DEL_W){1'b0}}, del_q};
    assign del_nxt = del_q + DEL_W'(2);
    assign cnt_nxt = cnt_q + OP_W'(1);
    assign eq      = (cnt_q == a_q);
    assign sq      = sq_q;

    // Operand register: captured on the accepting edge only, immune to later changes of a.
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            a_q <= '0;
        end else if (en_a) begin
            a_q <= a;
        end
    end

    // Working registers: initialised on accept, then one odd term added per step.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            cnt_q <= '0;
            del_q <= '0;
            acc_q <= '0;
        end else if (en_calc) begin
            if (ld_add) begin
                cnt_q <= '0;
                del_q <= DEL_W'(1);
                acc_q <= '0;
            end else begin
                cnt_q <= cnt_nxt;
                del_q <= del_nxt;
                acc_q <= acc_sum;
            end
        end
    end

    // Output register: written once per operation, held until the next result or clr.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            sq_q <= '0;
        end else if (en_out) begin
            sq_q <= acc_q;
        end
    end

endmodule : eight_bit_int_square_finder_datapath

// File: rtl/eight_bit_int_square_finder.sv
// Sequential 8-bit squarer: controller FSM driving the odd-sum datapath,
// with a single-cycle start/done handshake and a held result.
module eight_bit_int_square_finder
    import eight_bit_int_square_finder_pkg::*;
(
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic [OP_W-1:0]  a,
    output logic [RES_W-1:0] sq,
    output logic             done,
    output logic             busy
);

    state_t state_q;
    logic   done_q;
    logic   busy_q;

    logic   en_a;
    logic   en_calc;
    logic   en_out;
    logic   ld_add;
    logic   eq;

    // Datapath control decoded from the current state and handshake inputs.
    // NOTE: every signal gets a default before the case so no latch is inferred.
    always_comb begin
        en_a    = 1'b0;
        en_calc = 1'b0;
        en_out  = 1'b0;
        ld_add  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    en_a    = 1'b1;
                    en_calc = 1'b1;
                    ld_add  = 1'b1;
                end
            end
            S_CALC: begin
                if (eq) begin
                    en_out = 1'b1;
                end else begin
                    en_calc = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Controller FSM; done/busy are registered with the state so they track it glitch-free.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q <= S_IDLE;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q <= S_CALC;
                        busy_q  <= 1'b1;
                    end
                    done_q <= 1'b0;
                end
                S_CALC: begin
                    if (eq) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                    end
                    busy_q <= 1'b1;
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: begin
                    // Unused encoding: fall back to a quiet IDLE.
                    state_q <= S_IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign done = done_q;
    assign busy = busy_q;

    eight_bit_int_square_finder_datapath u_datapath (
        .clk     (clk),
        .clr     (clr),
        .en_a    (en_a),
        .en_calc (en_calc),
        .en_out  (en_out),
        .ld_add  (ld_add),
        .a       (a),
        .eq      (eq),
        .sq      (sq)
    );

endmodule : eight_bit_int_square_finder

// File: doc/eight_bit_int_square_finder.md
# eight_bit_int_square_finder

Sequential 8-bit integer squarer built on the same controller-datapath split as the team's square-root finder, and its inverse: it accumulates successive odd numbers 1, 3, 5, … until it has summed `a` of them, so the result is `a*a`. It is used to check and reconstruct square-root results (`sqrt*sqrt <= a`). It uses a single-cycle start / done handshake and holds its result until the next operation.

## Interface
- No parameters. Widths are fixed: 8-bit operand, 16-bit result.
- `clk` input 1: single clock; all state changes on the rising edge.
- `clr` input 1: reset, asynchronous, active-high.
- `start` input 1: request; sampled only in IDLE.
- `a` input 8: operand, unsigned; sampled on the accepting edge only.
- `sq` output 16: result `a*a`, unsigned; registered; held until the next accepted start.
- `done` output 1: high for exactly one cycle when `sq` becomes valid.
- `busy` output 1: high from the accept edge until `done` deasserts.

## Operation
- **Registers:**
  - `A`, 8 bits: latched operand.
  - `CNT`, 8 bits: number of odd terms added so far.
  - `DEL`, 10 bits: next odd number; its maximum is 511.
  - `ACC`, 16 bits: running sum.
  - `SQ`, 16 bits: output register.
- **States:** IDLE, CALC, DONE. One-hot or binary encoding is allowed; behaviour must be identical.
- **IDLE:**
  - `busy=0`, `done=0`.
  - On a rising edge with `start=1`: `A<=a`, `CNT<=0`, `ACC<=0`, `DEL<=1`, go to CALC.
  - `SQ` is untouched until DONE.
- **CALC, one step per edge:**
  - If `CNT != A`: `ACC<=ACC+DEL`, `DEL<=DEL+2`, `CNT<=CNT+1`; stay in CALC.
  - If `CNT == A`: `SQ<=ACC`, go to DONE.
- **DONE:**
  - `done=1`, `busy=1`.
  - On the next edge, go to IDLE unconditionally.
- **Arithmetic:** unsigned, with no overflow possible. For `a=255`, `ACC` reaches 65025 and `DEL` reaches 511. Adders are exactly the register widths.
- **Boundary conditions:**
  - `a=0`: the first CALC edge sees `CNT==A`, giving `SQ=0` after zero additions.
  - `start` high during CALC or DONE is ignored. It is not queued.
  - `start` held high continuously: a new operation is accepted on the first edge spent in IDLE after DONE.
  - `a` changing after acceptance has no effect on the running operation.
  - `clr` asserted at any time: immediately (asynchronously) forces state=IDLE and all registers to 0, so `sq=0`, `done=0`, `busy=0`. The operation in flight is lost.
  - When `clr` deasserts, the next edge is an ordinary IDLE edge.

## Timing
- **Reset values:** `sq=0x0000`, `done=0`, `busy=0`.
- **Latency:** call the accepting edge E0.
  - CALC spans edges E1..E(a+1).
  - `SQ` is written and DONE is entered at E(a+1).
  - `done` is high in the cycle between E(a+1) and E(a+2).
  - `busy` is high from E0 to E(a+2).
- **Throughput:** one operation per a+3 cycles when `start` is held high.
- **Output decode:** `done` and `busy` are Moore outputs decoded from the state register, so they are glitch-free relative to `clk`.
- **Result validity:** `sq` changes only at E(a+1) or on `clr`.

## Structure
- **Controller:** `eight_bit_int_square_finder`. It holds the FSM and drives the register enables and the load/add select (`ld_add`).
- **Datapath sub-module:** `eight_bit_int_square_finder_datapath`. It holds `A`, `CNT`, `DEL`, `ACC` and `SQ`, the two adders and the `CNT==A` comparator. Its ports are `en_a`, `en_calc`, `en_out`, `ld_add` and `eq`.
- **Shared package:** the state-encoding constants (`S_IDLE`, `S_CALC`, `S_DONE`) and the width constants (operand 8, result 16, delta 10). The square-root finder benches reuse these.

## Test plan
- **Reset:** assert `clr` mid-CALC with `a=200` → `sq=0`, `done=0`, `busy=0` immediately. Then `start` with `a=3` → `sq=9`.
- **Basic operation:** `start` with `a=5` → `done` is high exactly 6 cycles after the accepting edge, `sq=25`, and `sq` holds 25 until the next start.
- **Boundaries:**
  - `a=0` → `done` 1 cycle after E0, `sq=0`.
  - `a=255` → `done` 256 cycles after E0, `sq=65025` (0xFE01).
- **Ignored start:** start `a=10`, then pulse `start` with `a=7` during CALC and again during DONE → only `sq=100` results, one `done` pulse, and `busy` drops as specified.
- **Back-to-back:** hold `start` high with `a` cycling 1, 2, 3 → results 1, 4, 9, each accepted on the first IDLE edge.
- **Exhaustive cross-check:** for every `a` in 0..255, verify `sq==a*a`. Feed `sq` into the square-root finder and check the returned root equals `a`.
